// File: rtl/sigma_delta_pkg.sv
// Shared sigma-delta constants and helpers: oversample log2, integrator widths,
// saturating add. Common to the DAC and ADC paths.
package sigma_delta_pkg;

   localparam int unsigned WIDE_W = 64;

   typedef logic signed [WIDE_W-1:0] wide_t;

   function automatic int unsigned osr_log2(input int unsigned osr);
      return $clog2(osr);
   endfunction

   function automatic int unsigned i1_width(input int unsigned bitlen);
      return bitlen + 2;
   endfunction

   function automatic int unsigned i2_width(input int unsigned bitlen);
      return bitlen + 6;
   endfunction

   // Add in a wide domain, then clamp to the signed range of a w-bit register.
   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
      wide_t sum;
      wide_t hi;
      wide_t lo;
      sum = a + b;
      hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo  = -hi - wide_t'(1);
      if (sum > hi) begin
         return hi;
      end else if (sum < lo) begin
         return lo;
      end else begin
         return sum;
      end
   endfunction

endpackage

// File: rtl/sigma_delta_modulator.sv
// First/second-order 1-bit sigma-delta modulator with saturating integrators;
// the output bit is registered and drives the feedback of the next cycle.
module sigma_delta_modulator
   import sigma_delta_pkg::*;
#(
   parameter int unsigned MOD_ORDER  = 2,
   parameter int unsigned DAC_BITLEN = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DAC_BITLEN-1:0] x,
   output logic                         dac_bit
);

   localparam int unsigned I1_W = i1_width(DAC_BITLEN);
   localparam int unsigned I2_W = i2_width(DAC_BITLEN);

   logic signed [I1_W-1:0] i1;
   logic signed [I1_W-1:0] i1_next;
   logic signed [I2_W-1:0] i2;
   logic signed [I2_W-1:0] i2_next;
   wide_t                  fb;

   always_comb begin
      fb      = dac_bit ? (wide_t'(1) <<< (DAC_BITLEN - 1))
                        : -(wide_t'(1) <<< (DAC_BITLEN - 1));
      i1_next = I1_W'(sat_add(wide_t'(i1), wide_t'(x) - fb, I1_W));
      i2_next = I2_W'(sat_add(wide_t'(i2), wide_t'(i1_next) - fb, I2_W));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i1      <= '0;
         i2      <= '0;
         dac_bit <= 1'b0;
      end else begin
         i1      <= i1_next;
         i2      <= (MOD_ORDER == 2) ? i2_next : '0;
         dac_bit <= (MOD_ORDER == 1) ? !i1_next[I1_W-1] : !i2_next[I2_W-1];
      end
   end

endmodule

// File: rtl/sigma_delta_dac.sv
// Sigma-delta DAC top: one-entry sample holding register, phase counter,
// per-tick target update and optional linear interpolation into the modulator.
module sigma_delta_dac
   import sigma_delta_pkg::*;
#(
   parameter int unsigned OVERSAMPLE_RATE = 256,
   parameter int unsigned DAC_BITLEN      = 16,
   parameter int unsigned SIGNED_INPUT    = 1,
   parameter int unsigned MOD_ORDER       = 2,
   parameter int unsigned INTERP          = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DAC_BITLEN-1:0] dac_input,
   input  logic                  dac_valid,
   output logic                  dac_ready,
   output logic                  dac_pin,
   output logic                  dac_underrun
);

   localparam int unsigned L = osr_log2(OVERSAMPLE_RATE);
   localparam int unsigned B = DAC_BITLEN;

   logic [L-1:0]          phase;
   logic                  tick;
   logic                  accept;
   logic                  full;
   logic                  full_next;
   logic signed [B-1:0]   sample;
   logic signed [B-1:0]   hold;
   logic signed [B-1:0]   target;
   logic signed [B-1:0]   target_new;
   logic signed [B-1:0]   x;

   // Offset-binary samples become two's complement by flipping the MSB.
   assign sample     = (SIGNED_INPUT != 0) ? dac_input
                                           : (dac_input ^ {1'b1, {(B-1){1'b0}}});
   assign accept     = dac_valid && dac_ready;
   assign tick       = (phase == L'(OVERSAMPLE_RATE - 1));
   assign target_new = full ? hold : target;
   // A tick sees the pre-accept state, so a same-cycle accept waits for the next tick.
   assign full_next  = tick ? accept : (full | accept);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase        <= '0;
         full         <= 1'b0;
         hold         <= '0;
         target       <= '0;
         dac_ready    <= 1'b1;
         dac_underrun <= 1'b0;
      end else begin
         phase        <= phase + L'(1);
         full         <= full_next;
         dac_ready    <= !full_next;
         dac_underrun <= tick && !full;
         if (accept) begin
            hold <= sample;
         end
         if (tick) begin
            target <= target_new;
         end
      end
   end

   if (INTERP != 0) begin : g_lin
      localparam int unsigned ACC_W = B + L + 1;
      localparam int unsigned D_W   = B + 1;

      logic signed [ACC_W-1:0] acc;
      logic signed [D_W-1:0]   delta;

      // Ramp from the old target to the new one; lands exactly on it at the next tick.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            acc   <= '0;
            delta <= '0;
         end else if (tick) begin
            acc   <= ACC_W'(target) <<< L;
            delta <= D_W'(target_new) - D_W'(target);
         end else begin
            acc   <= acc + ACC_W'(delta);
         end
      end

      assign x = B'(acc >>> L);
   end else begin : g_zoh
      assign x = target;
   end

   sigma_delta_modulator #(
      .MOD_ORDER  (MOD_ORDER),
      .DAC_BITLEN (DAC_BITLEN)
   ) u_mod (
      .clk     (clk),
      .rst_n   (rst_n),
      .x       (x),
      .dac_bit (dac_pin)
   );

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac (OSR 256, 16-bit signed, 2nd order, linear interp).
module tb_sigma_delta_dac;

   localparam int unsigned HIST = 8192;

   logic        clk;
   logic        rst_n;
   logic [15:0] dac_input;
   logic        dac_valid;
   logic        dac_ready;
   logic        dac_pin;
   logic        dac_underrun;

   int vectors;
   int miscompares;
   int edge_n;
   int sent;
   int quota;
   int acc_edges[$];
   logic pin_hist   [0:HIST-1];
   logic ready_hist [0:HIST-1];
   logic und_hist   [0:HIST-1];

   sigma_delta_dac #(
      .OVERSAMPLE_RATE (256),
      .DAC_BITLEN      (16),
      .SIGNED_INPUT    (1),
      .MOD_ORDER       (2),
      .INTERP          (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dac_input    (dac_input),
      .dac_valid    (dac_valid),
      .dac_ready    (dac_ready),
      .dac_pin      (dac_pin),
      .dac_underrun (dac_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int count_ones(input int lo, input int hi);
      int c = 0;
      for (int e = lo; e <= hi; e++) c += int'(pin_hist[e]);
      return c;
   endfunction

   function automatic int count_und(input int lo, input int hi);
      int c = 0;
      for (int e = lo; e <= hi; e++) c += int'(und_hist[e]);
      return c;
   endfunction

   function automatic int count_ready(input int lo, input int hi);
      int c = 0;
      for (int e = lo; e <= hi; e++) c += int'(ready_hist[e]);
      return c;
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      dac_valid = 1'b0;
      dac_input = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
      sent   = 0;
      quota  = 0;
      acc_edges.delete();
   endtask

   // Producer offers dac_input while sent < quota; records per-edge outputs.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         logic will;
         dac_valid = (sent < quota);
         will      = dac_valid && dac_ready;
         @(posedge clk);
         #1;
         edge_n++;
         if (will) begin
            sent++;
            acc_edges.push_back(edge_n);
         end
         if (edge_n < int'(HIST)) begin
            pin_hist[edge_n]   = dac_pin;
            ready_hist[edge_n] = dac_ready;
            und_hist[edge_n]   = dac_underrun;
         end
      end
   endtask

   task automatic test_reset();
      bit exp_pins [0:6];
      exp_pins = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      rst_n     = 1'b0;
      dac_valid = 1'b0;
      dac_input = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (dac_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b want 1", dac_ready);
      end
      vectors++;
      if (dac_pin !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pin: got %b want 0", dac_pin);
      end
      vectors++;
      if (dac_underrun !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_underrun: got %b want 0", dac_underrun);
      end
      do_reset();
      run(257);
      for (int i = 0; i < 7; i++) begin
         vectors++;
         if (pin_hist[i+1] !== exp_pins[i]) begin
            miscompares++;
            $display("FAIL first_pins[%0d]: got %b want %b", i + 1, pin_hist[i+1], exp_pins[i]);
         end
      end
      vectors++;
      if (und_hist[255] !== 1'b0 || und_hist[256] !== 1'b1 || und_hist[257] !== 1'b0) begin
         miscompares++;
         $display("FAIL first_tick_underrun: got %b%b%b want 010",
                  und_hist[255], und_hist[256], und_hist[257]);
      end
   endtask

   task automatic test_back_to_back();
      int obs;
      do_reset();
      dac_input = 16'h0000;
      quota     = 1000;
      run(1024);
      for (int i = 0; i < 4; i++) begin
         obs = (i < acc_edges.size()) ? acc_edges[i] : -1;
         vectors++;
         if (obs !== 1 + 256 * i) begin
            miscompares++;
            $display("FAIL accept_edge[%0d]: got %0d want %0d", i, obs, 1 + 256 * i);
         end
      end
      vectors++;
      if (acc_edges.size() != 4) begin
         miscompares++;
         $display("FAIL accept_count: got %0d want 4", acc_edges.size());
      end
      vectors++;
      if (count_ready(1, 255) != 0 || ready_hist[256] !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_window: high_count %0d (want 0), edge256 %b (want 1)",
                  count_ready(1, 255), ready_hist[256]);
      end
      vectors++;
      if (count_und(1, 1024) != 0) begin
         miscompares++;
         $display("FAIL stream_underruns: got %0d want 0", count_und(1, 1024));
      end
      vectors++;
      if (count_ones(769, 1024) < 126 || count_ones(769, 1024) > 130) begin
         miscompares++;
         $display("FAIL zero_density: got %0d want 126..130", count_ones(769, 1024));
      end
   endtask

   task automatic test_full_scale();
      do_reset();
      dac_input = 16'h7FFF;
      quota     = 4;
      run(1024);
      vectors++;
      if (count_ones(769, 1024) < 254) begin
         miscompares++;
         $display("FAIL pos_full_density: got %0d want >=254", count_ones(769, 1024));
      end
      dac_input = 16'h8000;
      quota     = 8;
      run(1024);
      vectors++;
      if (count_ones(1793, 2048) > 2) begin
         miscompares++;
         $display("FAIL neg_full_density: got %0d want <=2", count_ones(1793, 2048));
      end
      vectors++;
      if (count_und(1, 2048) != 0) begin
         miscompares++;
         $display("FAIL full_scale_underruns: got %0d want 0", count_und(1, 2048));
      end
   endtask

   task automatic test_underrun_resume();
      do_reset();
      dac_input = 16'h4000;
      quota     = 2;
      run(1290);
      vectors++;
      if (count_und(1, 1290) != 3) begin
         miscompares++;
         $display("FAIL underrun_count: got %0d want 3", count_und(1, 1290));
      end
      vectors++;
      if (und_hist[768] !== 1'b1 || und_hist[1024] !== 1'b1 || und_hist[1280] !== 1'b1
          || und_hist[769] !== 1'b0) begin
         miscompares++;
         $display("FAIL underrun_edges: got %b%b%b%b want 1110",
                  und_hist[768], und_hist[1024], und_hist[1280], und_hist[769]);
      end
      vectors++;
      if (count_ones(1025, 1280) < 189 || count_ones(1025, 1280) > 195) begin
         miscompares++;
         $display("FAIL hold_density: got %0d want 189..195", count_ones(1025, 1280));
      end
      quota = 5;
      run(810);
      vectors++;
      if (count_und(1291, 2100) != 0) begin
         miscompares++;
         $display("FAIL resume_underruns: got %0d want 0", count_und(1291, 2100));
      end
      vectors++;
      if (acc_edges.size() != 5) begin
         miscompares++;
         $display("FAIL resume_accepts: got %0d want 5", acc_edges.size());
      end
   endtask

   task automatic test_interp_step();
      int peak;
      do_reset();
      dac_input = 16'h4000;
      quota     = 1;
      run(768);
      vectors++;
      if (count_ones(1, 256) < 126 || count_ones(1, 256) > 130) begin
         miscompares++;
         $display("FAIL pre_step_density: got %0d want 126..130", count_ones(1, 256));
      end
      vectors++;
      if (count_ones(257, 512) < 155 || count_ones(257, 512) > 165) begin
         miscompares++;
         $display("FAIL ramp_density: got %0d want 155..165", count_ones(257, 512));
      end
      vectors++;
      if (count_ones(257, 320) >= count_ones(449, 512)) begin
         miscompares++;
         $display("FAIL ramp_rising: first_quarter %0d last_quarter %0d want first<last",
                  count_ones(257, 320), count_ones(449, 512));
      end
      peak = 0;
      for (int w = 257; w + 31 <= 768; w += 32) begin
         if (count_ones(w, w + 31) > peak) peak = count_ones(w, w + 31);
      end
      vectors++;
      if (peak > 26) begin
         miscompares++;
         $display("FAIL ramp_overshoot: peak %0d per 32 want <=26", peak);
      end
      vectors++;
      if (count_ones(513, 768) < 189 || count_ones(513, 768) > 195) begin
         miscompares++;
         $display("FAIL step_final_density: got %0d want 189..195", count_ones(513, 768));
      end
   endtask

   task automatic test_reset_midramp();
      do_reset();
      dac_input = 16'h4000;
      quota     = 2;
      run(384);
      vectors++;
      if (ready_hist[384] !== 1'b0) begin
         miscompares++;
         $display("FAIL midramp_full: ready got %b want 0", ready_hist[384]);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (dac_pin !== 1'b0 || dac_ready !== 1'b1 || dac_underrun !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: pin/ready/underrun got %b%b%b want 010",
                  dac_pin, dac_ready, dac_underrun);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (dac_pin !== 1'b0 || dac_ready !== 1'b1 || dac_underrun !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_next_cycle: pin/ready/underrun got %b%b%b want 010",
                  dac_pin, dac_ready, dac_underrun);
      end
      do_reset();
      dac_input = 16'h0000;
      quota     = 1;
      run(1024);
      vectors++;
      if (pin_hist[1] !== 1'b1 || pin_hist[2] !== 1'b1 || pin_hist[3] !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_pins: got %b%b%b want 110",
                  pin_hist[1], pin_hist[2], pin_hist[3]);
      end
      vectors++;
      if (acc_edges.size() != 1 || acc_edges[0] != 1) begin
         miscompares++;
         $display("FAIL post_reset_accept: count %0d want 1 at edge 1", acc_edges.size());
      end
      vectors++;
      if (count_ones(769, 1024) < 126 || count_ones(769, 1024) > 130) begin
         miscompares++;
         $display("FAIL post_reset_density: got %0d want 126..130", count_ones(769, 1024));
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      edge_n      = 0;
      sent        = 0;
      quota       = 0;
      rst_n       = 1'b0;
      dac_valid   = 1'b0;
      dac_input   = '0;
      test_reset();
      test_back_to_back();
      test_full_scale();
      test_underrun_resume();
      test_interp_step();
      test_reset_midramp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
